// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
// The master issues MULTU/DIVU and reads HI/LO; the slave is the sequencer itself.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, DataA, DataB,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, DataA, DataB,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU unit: one shift-add or restoring-divide step per clock,
// with HI/LO written only when an operation completes.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   mdu_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  // Multiply: acc = {partial product, remaining multiplier}; opb_q holds the multiplicand.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}. The shifted remainder can need WIDTH+1 bits,
  // so the trial subtraction carries one more bit as its sign.
  logic [WIDTH:0]       div_rem_sh;
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_next;

  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial  = {1'b0, div_rem_sh} - {2'b00, opb_q};
  assign div_next   = div_trial[WIDTH+1] ?
                      {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                      {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0]   step_res;
  assign step_res = op_q ? div_next : mul_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (mdu_io.Start) begin
          op_d  = mdu_io.Op;
          cnt_d = CNT_W'(WIDTH - 1);
          if (mdu_io.Op) begin
            opb_d = mdu_io.DataB;
            acc_d = {{WIDTH{1'b0}}, mdu_io.DataA};
          end else begin
            opb_d = mdu_io.DataA;
            acc_d = {{WIDTH{1'b0}}, mdu_io.DataB};
          end
          if (mdu_io.Op && (mdu_io.DataB == '0)) begin
            state_d = StDone;
            hi_d    = mdu_io.DataA;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            dbz_d   = 1'b0;
          end
        end
      end
      StRun: begin
        acc_d = step_res;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          hi_d    = step_res[2*WIDTH-1:WIDTH];
          lo_d    = step_res[WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        dbz_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign mdu_io.Busy      = (state_q == StRun);
  assign mdu_io.Done      = (state_q == StDone);
  assign mdu_io.DivByZero = dbz_q;
  assign mdu_io.Hi        = hi_q;
  assign mdu_io.Lo        = lo_q;

endmodule
